muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller that sits beside the EXECUTION ALU in the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU from the D/X stage and runs an iterative shift-add multiplier or a restoring divider, one bit per cycle. It drives a stall to hold the pipeline while busy, owns the architectural HI/LO registers, and services MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
op_valid  in  1  D/X holds a mul/div instruction
op_code  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
A  in  WIDTH  rs operand (multiplicand / dividend)
B  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort in-flight op (branch/exception squash)
mt_hi  in  1  MTHI write strobe
mt_lo  in  1  MTLO write strobe
mt_data  in  WIDTH  MTHI/MTLO data
stall  out  1  hold IF/ID/EX pipeline registers
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: HI/LO hold the new result
div0  out  1  last accepted divide had B == 0; sticky until next accept
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst==0 at clock edge): state IDLE; hi, lo, counter and internal regs = 0; stall=0, busy=0, done=0, div0=0. Reset mid-operation discards the op.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: op_valid=1 -> accept. Latch A, B, op_code, and sign flags sa=A[WIDTH-1], sb=B[WIDTH-1] (signed ops only). Go to PREP. stall is combinationally 1 in the accept cycle.
- PREP (1 cycle): signed ops replace operands with their magnitudes. Clear accumulator. Counter = WIDTH. Set div0 = (divide && B==0).
- ITER (WIDTH cycles, counter decrements each cycle):
  - Multiply: if multiplier LSB is 1, add multiplicand into the upper accumulator half; shift the 2*WIDTH accumulator right by 1.
  - Divide (restoring): shift {rem, quo} left by 1; trial-subtract the divisor from rem; if no borrow, keep the difference and set quo LSB.
  - Counter reaching 0 -> FIX.
- FIX (1 cycle), writes hi/lo:
  - Multiply: {hi,lo} = product, two's-complement negated over 2*WIDTH bits when signed and sa^sb.
  - Divide: lo = quotient, negated if signed and sa^sb; hi = remainder, negated if signed and sa.
  - Divide by zero (either sign): lo = all ones, hi = original A.
  - Signed -2^(WIDTH-1) / -1: lo = 0x80000000, hi = 0; no trap.
- DONE (1 cycle): done=1, stall=0 so the instruction leaves EX. op_valid is ignored. Unconditional transition to IDLE.
- stall = (IDLE && op_valid) || PREP || ITER || FIX. busy = (state != IDLE).
- Total latency: done is high WIDTH+3 cycles after the accept cycle (35 for WIDTH=32). Pipeline stalled for WIDTH+3 cycles.
- flush: in PREP, ITER or FIX -> IDLE next cycle; hi/lo and div0 unchanged; no done. Flush in IDLE blocks acceptance that cycle. Flush in DONE has no effect (result already committed).
- mt_hi/mt_lo: honoured only in IDLE or DONE; write hi/lo at the edge. Ignored while busy in PREP/ITER/FIX, since stall guarantees the pipeline cannot issue them.
- mt write in IDLE together with op_valid: the write happens; the new op latches the pre-write operands and later overwrites hi/lo.
- All arithmetic is modulo width; no overflow flag for multiply.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: multiply leaves ITER as soon as the remaining unshifted multiplier bits are all zero. The accumulator is realigned in FIX by the remaining count (barrel shift). Latency is min WIDTH+3 - (leading zeros of |B|), floor 4 cycles from accept to done. Divide timing is unchanged.
- Undefined: fixed WIDTH+3 latency for all ops; no barrel shifter is synthesized.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at accept+35; hi=0xFFFFFFFE, lo=0x00000001; stall high cycles 0..34, low at 35.
- MULT A=-3 (0xFFFFFFFD) B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV A=-7 B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=0x12345678 B=0 -> div0=1, lo=0xFFFFFFFF, hi=0x12345678. Next accepted MULTU clears div0.
- MTHI 0xAAAA0000 in IDLE, start MULTU 5*6, assert flush at accept+10 -> busy=0 at accept+11, no done, hi=0xAAAA0000, lo unchanged.
- rst=0 asserted at accept+20 of a DIVU -> next cycle hi=lo=0, stall=busy=done=div0=0. A new op issued after reset completes at accept+35 with the correct result.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the D/X stage and the iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, A, B, flush, mt_hi, mt_lo, mt_data,
    input  stall, busy, done, div0, hi, lo
  );

  modport slave (
    input  op_valid, op_code, A, B, flush, mt_hi, mt_lo, mt_data,
    output stall, busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle with pipeline stall.
// Optional macro MULDIV_EARLY_OUT_EN: multiply exits ITER once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ZERO_P   = {PW{1'b0}};
  localparam logic [PW-1:0]    ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] x);
    return ~x + ONE_P;
  endfunction

  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic is_neg);
    return is_neg ? neg_w(x) : x;
  endfunction

  state_t state_r, state_s;

  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, addend_r;
  logic             sa_r, sb_r;
  logic [PW-1:0]    acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             div0_r;

  logic             accept_s, is_div_s, is_signed_s;
  logic [WIDTH:0]   mul_sum_s, rem_sh_s;
  logic [PW-1:0]    mul_next_s, div_next_s, iter_acc_s;
  logic             take_s;
  logic [WIDTH-1:0] diff_s;
  logic [CNT_W-1:0] cnt_dec_s;
  logic             iter_last_s;
  logic [PW-1:0]    fix_acc_s, prod_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
  logic             stall_s, busy_s, done_s;

  assign is_div_s    = op_r[1];
  assign is_signed_s = op_r[0];
  assign accept_s    = (state_r == S_IDLE) && bus.op_valid && !bus.flush;

  // One multiply step (shift-add) and one restoring-divide step on the shared accumulator.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, addend_r};
    if (acc_r[0]) begin
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else begin
      mul_next_s = {1'b0, acc_r[PW-1:1]};
    end
    // Shifted remainder can need WIDTH+1 bits before the trial subtract.
    rem_sh_s = acc_r[PW-1:WIDTH-1];
    take_s   = (rem_sh_s >= {1'b0, addend_r});
    diff_s   = rem_sh_s[WIDTH-1:0] - addend_r;
    if (take_s) begin
      div_next_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
    if (is_div_s) begin
      iter_acc_s = div_next_s;
    end else begin
      iter_acc_s = mul_next_s;
    end
    cnt_dec_s = cnt_r - ONE_C;
`ifdef MULDIV_EARLY_OUT_EN
    if (is_div_s) begin
      iter_last_s = (cnt_dec_s == ZERO_C);
    end else begin
      iter_last_s = (cnt_dec_s == ZERO_C) ||
                    ((mul_next_s[WIDTH-1:0] & ~(ONES_W << cnt_dec_s)) == ZERO_W);
    end
`else
    iter_last_s = (cnt_dec_s == ZERO_C);
`endif
  end

  // Sign fix-up and special cases applied when the result is committed to HI/LO.
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    fix_acc_s = acc_r >> cnt_r;
`else
    fix_acc_s = acc_r;
`endif
    if (is_signed_s && (sa_r ^ sb_r)) begin
      prod_s = neg_p(fix_acc_s);
    end else begin
      prod_s = fix_acc_s;
    end
    if (!is_div_s) begin
      fix_hi_s = prod_s[PW-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (addend_r == ZERO_W) begin
      fix_hi_s = a_r;
      fix_lo_s = ONES_W;
    end else begin
      // -2^(WIDTH-1) / -1 falls out naturally: quotient magnitude 2^(WIDTH-1), remainder 0.
      fix_lo_s = (is_signed_s && (sa_r ^ sb_r)) ? neg_w(fix_acc_s[WIDTH-1:0])
                                                : fix_acc_s[WIDTH-1:0];
      fix_hi_s = (is_signed_s && sa_r) ? neg_w(fix_acc_s[PW-1:WIDTH])
                                       : fix_acc_s[PW-1:WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush aborts anything not yet in DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_PREP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PREP: begin
        if (bus.flush) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_ITER;
        end
      end
      S_ITER: begin
        if (bus.flush) begin
          state_s = S_IDLE;
        end else if (iter_last_s) begin
          state_s = S_FIX;
        end else begin
          state_s = S_ITER;
        end
      end
      S_FIX: begin
        if (bus.flush) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    stall_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        stall_s = bus.op_valid;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
      S_PREP, S_ITER, S_FIX: begin
        stall_s = 1'b1;
        busy_s  = 1'b1;
        done_s  = 1'b0;
      end
      S_DONE: begin
        stall_s = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Operand capture, magnitude preparation and iteration datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r     <= 2'b00;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      addend_r <= ZERO_W;
      acc_r    <= ZERO_P;
      cnt_r    <= ZERO_C;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r <= bus.op_code;
            a_r  <= bus.A;
            b_r  <= bus.B;
            sa_r <= bus.op_code[0] & bus.A[WIDTH-1];
            sb_r <= bus.op_code[0] & bus.B[WIDTH-1];
          end
        end
        S_PREP: begin
          if (is_div_s) begin
            addend_r <= mag_w(b_r, sb_r);
            acc_r    <= {ZERO_W, mag_w(a_r, sa_r)};
          end else begin
            addend_r <= mag_w(a_r, sa_r);
            acc_r    <= {ZERO_W, mag_w(b_r, sb_r)};
          end
          cnt_r <= CNT_INIT;
        end
        S_ITER: begin
          acc_r <= iter_acc_s;
          cnt_r <= cnt_dec_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Architectural HI/LO and the sticky divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_r   <= ZERO_W;
      lo_r   <= ZERO_W;
      div0_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.mt_hi) begin
            hi_r <= bus.mt_data;
          end
          if (bus.mt_lo) begin
            lo_r <= bus.mt_data;
          end
        end
        S_PREP: begin
          if (!bus.flush) begin
            div0_r <= is_div_s && (b_r == ZERO_W);
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
          end
        end
        default: begin
          div0_r <= div0_r;
        end
      endcase
    end
  end

  assign bus.stall = stall_s;
  assign bus.busy  = busy_s;
  assign bus.done  = done_s;
  assign bus.div0  = div0_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic with C-style truncating signed divide.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo, output logic md0);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    md0 = 1'b0;
    mhi = 32'h0;
    mlo = 32'h0;
    case (op)
      2'b00: begin p = 64'(a) * 64'(b); mhi = p[63:32]; mlo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb);    mhi = p[63:32]; mlo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          md0 = 1'b1; mlo = 32'hFFFFFFFF; mhi = a;
        end else if (op == 2'b10) begin
          mlo = a / b; mhi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          mlo = q[31:0]; mhi = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    int lat;
    lat = 35;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      logic [31:0] mag;
      int nbits;
      mag = (op[0] && b[31]) ? (32'h0 - b) : b;
      nbits = 0;
      for (int k = 0; k < 32; k++) if (mag[k]) nbits = k + 1;
      lat = (nbits + 3 < 4) ? 4 : nbits + 3;
    end
`endif
    return lat;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1; bus.op_code = op; bus.A = a; bus.B = b;
    tick();
    bus.op_valid = 1'b0; bus.A = $urandom; bus.B = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic with_mt);
    logic [31:0] mhi, mlo;
    logic md0, stall_ok;
    int cyc, lat;
    model(op, a, b, mhi, mlo, md0);
    lat = exp_latency(op, b);
    bus.op_valid = 1'b1; bus.op_code = op; bus.A = a; bus.B = b;
    if (with_mt) begin
      bus.mt_lo = 1'b1; bus.mt_data = 32'h0055AA00;
    end
    #1;
    stall_ok = (bus.stall === 1'b1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0; bus.mt_lo = 1'b0; bus.A = $urandom; bus.B = $urandom;
    if (with_mt) check("mt_lo_with_op", {32'h0, bus.lo}, {32'h0, 32'h0055AA00});
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    check("latency", 64'(cyc), 64'(lat));
    check("stall_profile", {63'h0, stall_ok}, 64'h1);
    check("stall_at_done", {63'h0, bus.stall}, 64'h0);
    check("hi", {32'h0, bus.hi}, {32'h0, mhi});
    check("lo", {32'h0, bus.lo}, {32'h0, mlo});
    check("div0", {63'h0, bus.div0}, {63'h0, md0});
    last_hi = mhi;
    last_lo = mlo;
    tick();
    check("idle_after_done", {63'h0, bus.busy}, 64'h0);
  endtask

  initial begin
    logic seen;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.A = 32'h0; bus.B = 32'h0;
    bus.flush = 1'b0; bus.mt_hi = 1'b0; bus.mt_lo = 1'b0; bus.mt_data = 32'h0;
    repeat (3) tick();
    check("rst_stall", {63'h0, bus.stall}, 64'h0);
    check("rst_busy",  {63'h0, bus.busy},  64'h0);
    check("rst_done",  {63'h0, bus.done},  64'h0);
    check("rst_div0",  {63'h0, bus.div0},  64'h0);
    check("rst_hi", {32'h0, bus.hi}, 64'h0);
    check("rst_lo", {32'h0, bus.lo}, 64'h0);
    rst = 1'b1;
    tick();

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_max_hi", {32'h0, bus.hi}, 64'hFFFFFFFE);
    check("multu_max_lo", {32'h0, bus.lo}, 64'h00000001);
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 1'b0);
    check("mult_neg_hi", {32'h0, bus.hi}, 64'hFFFFFFFF);
    check("mult_neg_lo", {32'h0, bus.lo}, 64'hFFFFFFEB);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    check("div_neg_lo", {32'h0, bus.lo}, 64'hFFFFFFFD);
    check("div_neg_hi", {32'h0, bus.hi}, 64'hFFFFFFFF);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo", {32'h0, bus.lo}, 64'h80000000);
    check("div_ovf_hi", {32'h0, bus.hi}, 64'h0);
    run_op(2'b10, 32'h12345678, 32'h0, 1'b0);
    check("divu0_div0", {63'h0, bus.div0}, 64'h1);
    check("divu0_lo", {32'h0, bus.lo}, 64'hFFFFFFFF);
    check("divu0_hi", {32'h0, bus.hi}, 64'h12345678);
    run_op(2'b00, 32'h3, 32'h4, 1'b0);
    check("div0_cleared", {63'h0, bus.div0}, 64'h0);

    // MTHI then flushed MULTU: HI keeps the written value, LO keeps the prior result.
    bus.mt_hi = 1'b1; bus.mt_data = 32'hAAAA0000;
    tick();
    bus.mt_hi = 1'b0;
    check("mthi", {32'h0, bus.hi}, 64'hAAAA0000);
    start_op(2'b00, 32'h5, 32'h6);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", {63'h0, bus.busy}, 64'h0);
    check("flush_stall", {63'h0, bus.stall}, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      if (bus.done === 1'b1) seen = 1'b1;
      tick();
    end
    check("flush_no_done", {63'h0, seen}, 64'h0);
    check("flush_hi", {32'h0, bus.hi}, 64'hAAAA0000);
    check("flush_lo", {32'h0, bus.lo}, {32'h0, last_lo});

    // Flush in IDLE blocks the accept.
    bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.A = 32'h9; bus.B = 32'h9; bus.flush = 1'b1;
    tick();
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    check("idle_flush_blocks", {63'h0, bus.busy}, 64'h0);

    run_op(2'b01, 32'h00001234, 32'hFFFFFF00, 1'b1);

    // Reset in the middle of a DIVU discards it.
    start_op(2'b10, 32'h12345678, 32'h0);
    repeat (19) tick();
    rst = 1'b0;
    tick();
    check("midrst_hi", {32'h0, bus.hi}, 64'h0);
    check("midrst_lo", {32'h0, bus.lo}, 64'h0);
    check("midrst_stall", {63'h0, bus.stall}, 64'h0);
    check("midrst_busy", {63'h0, bus.busy}, 64'h0);
    check("midrst_done", {63'h0, bus.done}, 64'h0);
    check("midrst_div0", {63'h0, bus.div0}, 64'h0);
    rst = 1'b1;
    tick();
    run_op(2'b10, 32'd1000, 32'd7, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 15));
        default: rb = rb;
      endcase
      run_op(rop, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
